execute_mc: RTL

EXECUTE_MC -- requirements
Module: execute_mc

---
 rtl/execute_mc_pkg.sv | 36 +++
 rtl/execute_mc_if.sv | 49 ++++
 rtl/execute_mc_mul_iter.sv | 79 +++++++
 rtl/execute_mc.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/execute_mc_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, control-bit layout,
// FSM state encoding and the zero-register number.
package exec_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    localparam int CTRL_REGWRITE = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_UNCOND   = 3;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEM2REG  = 0;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } ex_state_e;

    // ALUSrc is consumed in EX, so it is dropped on the way to MEM.
    function automatic logic [5:0] ctrl_to_mem(input logic [6:0] c);
        return {c[CTRL_REGWRITE], c[CTRL_BRANCH], c[CTRL_UNCOND],
                c[CTRL_MEMREAD], c[CTRL_MEMWRITE], c[CTRL_MEM2REG]};
    endfunction

endpackage

// File: rtl/execute_mc_if.sv
// Issue, forwarding and EX/MEM signals of the execute stage; the stage itself
// connects through the slave modport.
interface execute_mc_if #(parameter int XLEN = 64);

    logic            valid_ex;
    logic [6:0]      ctrl_ex;
    logic [3:0]      aluop_ex;
    logic [4:0]      rn_ex;
    logic [4:0]      rm_ex;
    logic [4:0]      rd_ex;
    logic [XLEN-1:0] rega_ex;
    logic [XLEN-1:0] regb_ex;
    logic [XLEN-1:0] imm_ex;
    logic [XLEN-1:0] pc_ex;
    logic            fwd_mem_we;
    logic [4:0]      fwd_mem_rd;
    logic [XLEN-1:0] fwd_mem_val;
    logic            fwd_wb_we;
    logic [4:0]      fwd_wb_rd;
    logic [XLEN-1:0] fwd_wb_val;
    logic            flush;
    logic            busy;
    logic            valid_mem;
    logic [5:0]      ctrl_mem;
    logic [4:0]      rd_mem;
    logic [XLEN-1:0] regb_mem;
    logic [XLEN-1:0] aluout_mem;
    logic [XLEN-1:0] pctarget_mem;
    logic            aluzero_mem;

    modport master (
        output valid_ex, ctrl_ex, aluop_ex, rn_ex, rm_ex, rd_ex,
               rega_ex, regb_ex, imm_ex, pc_ex,
               fwd_mem_we, fwd_mem_rd, fwd_mem_val,
               fwd_wb_we, fwd_wb_rd, fwd_wb_val, flush,
        input  busy, valid_mem, ctrl_mem, rd_mem, regb_mem,
               aluout_mem, pctarget_mem, aluzero_mem
    );

    modport slave (
        input  valid_ex, ctrl_ex, aluop_ex, rn_ex, rm_ex, rd_ex,
               rega_ex, regb_ex, imm_ex, pc_ex,
               fwd_mem_we, fwd_mem_rd, fwd_mem_val,
               fwd_wb_we, fwd_wb_rd, fwd_wb_val, flush,
        output busy, valid_mem, ctrl_mem, rd_mem, regb_mem,
               aluout_mem, pctarget_mem, aluzero_mem
    );

endinterface

// File: rtl/execute_mc_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, XLEN cycles.
// done_o flags the final iteration; product_o is valid the cycle after.
module mul_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            run_q,    run_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q,    acc_d;

    // Iteration step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (abort_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = {CW{1'b0}};
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = {XLEN{1'b0}};
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end else begin
                acc_d = acc_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end else begin
                run_d = 1'b1;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {XLEN{1'b0}};
            mplier_q <= {XLEN{1'b0}};
            acc_q    <= {XLEN{1'b0}};
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign done_o    = run_q & (cnt_q == LAST) & ~abort_i;
    assign product_o = acc_q;

endmodule

// File: rtl/execute_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch target and an
// iterative multiply that stalls upstream through busy.
module execute_mc
    import exec_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int BR_SHIFT = 0,
    parameter int MUL_EN   = 1
) (
    input  logic         clk,
    input  logic         reset,
    execute_mc_if.slave  ex
);

    ex_state_e state_q, state_d;

    logic            accept_s, is_mul_s, start_s, busy_s, mul_abort_s, mul_done_s;
    logic [XLEN-1:0] op_a_s, op_b_s, alu_b_s, alu_res_s, pct_s, product_s;
    logic [6:0]      shamt_s;

    logic            valid_q,    valid_d;
    logic [5:0]      ctrl_q,     ctrl_d;
    logic [4:0]      rd_q,       rd_d;
    logic [XLEN-1:0] regb_q,     regb_d;
    logic [XLEN-1:0] alu_q,      alu_d;
    logic            zero_q,     zero_d;
    logic [XLEN-1:0] pct_q,      pct_d;
    logic [5:0]      lat_ctrl_q, lat_ctrl_d;
    logic [4:0]      lat_rd_q,   lat_rd_d;
    logic [XLEN-1:0] lat_regb_q, lat_regb_d;
    logic [XLEN-1:0] lat_pct_q,  lat_pct_d;

    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [4:0]      src,
        input logic [XLEN-1:0] reg_val,
        input logic            m_we,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_val,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_val
    );
        logic [XLEN-1:0] r;
        if (src == XZR) begin
            r = reg_val;
        end else if (m_we && (m_rd == src)) begin
            r = m_val;
        end else if (w_we && (w_rd == src)) begin
            r = w_val;
        end else begin
            r = reg_val;
        end
        return r;
    endfunction

    assign is_mul_s = (MUL_EN != 32'sd0) && (ex.aluop_ex == ALU_MUL);

    // Operand selection with MEM-over-WB forwarding and the immediate mux.
    always_comb begin
        op_a_s  = fwd_pick(ex.rn_ex, ex.rega_ex, ex.fwd_mem_we, ex.fwd_mem_rd, ex.fwd_mem_val,
                           ex.fwd_wb_we, ex.fwd_wb_rd, ex.fwd_wb_val);
        op_b_s  = fwd_pick(ex.rm_ex, ex.regb_ex, ex.fwd_mem_we, ex.fwd_mem_rd, ex.fwd_mem_val,
                           ex.fwd_wb_we, ex.fwd_wb_rd, ex.fwd_wb_val);
        alu_b_s = ex.ctrl_ex[CTRL_ALUSRC] ? ex.imm_ex : op_b_s;
        pct_s   = ex.pc_ex + (ex.imm_ex << BR_SHIFT);
    end

    // Single-cycle ALU; MUL only lands here when the multiplier is compiled out.
    always_comb begin
        shamt_s = 7'(alu_b_s[5:0]) % 7'(XLEN);
        case (ex.aluop_ex)
            ALU_AND:   alu_res_s = op_a_s & alu_b_s;
            ALU_ORR:   alu_res_s = op_a_s | alu_b_s;
            ALU_ADD:   alu_res_s = op_a_s + alu_b_s;
            ALU_SUB:   alu_res_s = op_a_s - alu_b_s;
            ALU_PASSB: alu_res_s = alu_b_s;
            ALU_LSL:   alu_res_s = op_a_s << shamt_s;
            ALU_LSR:   alu_res_s = op_a_s >> shamt_s;
            ALU_MUL:   alu_res_s = alu_b_s;
            default:   alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (ex.flush) begin
                    state_d = ST_IDLE;
                end else if (mul_done_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; busy must rise in the issue cycle so upstream holds the MUL.
    always_comb begin
        accept_s    = 1'b0;
        start_s     = 1'b0;
        busy_s      = 1'b0;
        mul_abort_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept_s = ex.valid_ex & ~ex.flush;
                start_s  = accept_s & is_mul_s;
                busy_s   = start_s;
            end
            ST_MUL: begin
                busy_s      = 1'b1;
                mul_abort_s = ex.flush;
            end
            ST_DONE: mul_abort_s = ex.flush;
            default: busy_s = 1'b0;
        endcase
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            mul_iter #(.XLEN(XLEN)) u_mul (
                .clk       (clk),
                .reset     (reset),
                .start_i   (start_s),
                .abort_i   (mul_abort_s),
                .a_i       (op_a_s),
                .b_i       (alu_b_s),
                .done_o    (mul_done_s),
                .product_o (product_s)
            );
        end else begin : g_no_mul
            assign mul_done_s = 1'b0;
            assign product_s  = {XLEN{1'b0}};
        end
    endgenerate

    // EX/MEM next values: bubble by default, data fields hold.
    always_comb begin
        valid_d    = 1'b0;
        ctrl_d     = 6'b000000;
        rd_d       = rd_q;
        regb_d     = regb_q;
        alu_d      = alu_q;
        zero_d     = zero_q;
        pct_d      = pct_q;
        lat_ctrl_d = lat_ctrl_q;
        lat_rd_d   = lat_rd_q;
        lat_regb_d = lat_regb_q;
        lat_pct_d  = lat_pct_q;
        if ((state_q == ST_DONE) && !ex.flush) begin
            valid_d = 1'b1;
            ctrl_d  = lat_ctrl_q;
            rd_d    = lat_rd_q;
            regb_d  = lat_regb_q;
            alu_d   = product_s;
            zero_d  = (product_s == {XLEN{1'b0}});
            pct_d   = lat_pct_q;
        end else if (accept_s && !is_mul_s) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_to_mem(ex.ctrl_ex);
            rd_d    = ex.rd_ex;
            regb_d  = op_b_s;
            alu_d   = alu_res_s;
            zero_d  = (alu_res_s == {XLEN{1'b0}});
            pct_d   = pct_s;
        end else if (start_s) begin
            lat_ctrl_d = ctrl_to_mem(ex.ctrl_ex);
            lat_rd_d   = ex.rd_ex;
            lat_regb_d = op_b_s;
            lat_pct_d  = pct_s;
        end else begin
            valid_d = 1'b0;
            ctrl_d  = 6'b000000;
        end
    end

    // EX/MEM register and multiply side-band latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= 6'b000000;
            rd_q       <= 5'd0;
            regb_q     <= {XLEN{1'b0}};
            alu_q      <= {XLEN{1'b0}};
            zero_q     <= 1'b0;
            pct_q      <= {XLEN{1'b0}};
            lat_ctrl_q <= 6'b000000;
            lat_rd_q   <= 5'd0;
            lat_regb_q <= {XLEN{1'b0}};
            lat_pct_q  <= {XLEN{1'b0}};
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            regb_q     <= regb_d;
            alu_q      <= alu_d;
            zero_q     <= zero_d;
            pct_q      <= pct_d;
            lat_ctrl_q <= lat_ctrl_d;
            lat_rd_q   <= lat_rd_d;
            lat_regb_q <= lat_regb_d;
            lat_pct_q  <= lat_pct_d;
        end
    end

    assign ex.busy         = busy_s;
    assign ex.valid_mem    = valid_q;
    assign ex.ctrl_mem     = ctrl_q;
    assign ex.rd_mem       = rd_q;
    assign ex.regb_mem     = regb_q;
    assign ex.aluout_mem   = alu_q;
    assign ex.aluzero_mem  = zero_q;
    assign ex.pctarget_mem = pct_q;

endmodule
